decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC/immediate width (32 or 64).
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous active-high (one clock, rising edge).
REQ-003 SHALL have ports: in_valid in 1; in_ready out 1; in_inst in 32; in_pc in XLEN; flush in 1 kill stage contents.
REQ-004 SHALL have ports: out_valid out 1; out_ready in 1; out_pc out XLEN; out_rd/out_rs1/out_rs2 out 5; out_imm out XLEN.
REQ-005 SHALL have control outputs: alu_op out 3; alu_imm, alu_sub, alu_sra, rd_w, ld_upper, add_pc, jmp_reg, is_branch, is_jmp, is_load, is_store, illegal, is_muldiv, each out 1.

Function
REQ-006 SHALL decode in_inst combinationally and register all out_* and control outputs on accept; latency exactly 1 cycle.
REQ-007 SHALL set accept = in_valid & in_ready; in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-008 SHALL on out_valid & out_ready without accept clear out_valid next cycle; with accept, load new entry (back-to-back, full throughput).
REQ-009 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-010 SHALL produce control encodings: RV32I base set, alu_op = funct3 for OP/OP-IMM, alu_op=000 for loads/stores/JALR, alu_sub only for SUB, alu_sra for SRA/SRAI.
REQ-011 SHALL generate out_imm per format I/S/B/U/J, sign-extended from inst[31] to XLEN; R-type imm = 0.
REQ-012 SHALL set illegal=1 for unknown opcode or in_inst[1:0] != 2'b11; then rd_w, is_load, is_store, is_branch, is_jmp = 0.
REQ-013 SHALL force rd_w=0 when rd=0 for every instruction.
REQ-014 SHALL assert hazard when out_valid & is_load & out_rd != 0 and incoming instruction reads out_rd via rs1 (all but LUI/AUIPC/JAL) or rs2 (OP, STORE, BRANCH).
REQ-015 SHALL on hazard insert exactly one bubble: load departs, out_valid=0 for one cycle, dependent instruction accepted the following cycle.
REQ-016 SHALL on flush clear out_valid next cycle and accept nothing that cycle; flush overrides out_ready and in_valid.

Reset
REQ-017 SHALL on rst clear out_valid and all control outputs to 0, out_imm/out_pc/out_rd/out_rs1/out_rs2 to 0.
REQ-018 SHALL drive in_ready=0 during rst; first accept possible the cycle after rst deasserts.
REQ-019 SHALL on rst mid-transfer discard the held entry without emitting it.

Configuration
REQ-020 SHALL with macro DECODE_MULDIV_EN defined decode OP funct7=0000001 as is_muldiv=1, rd_w=1, alu_op=funct3.
REQ-021 SHALL without DECODE_MULDIV_EN treat funct7=0000001 OP as illegal=1; is_muldiv tied 0.

Structure
REQ-022 SHALL place opcode constants, alu_op encodings and immediate-format enum in shared package riscv_pkg.
REQ-023 SHALL implement immediate generation as sub-module imm_gen (parameter XLEN, combinational).

Verification
REQ-024 SHALL check: in 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, rd_w=1, alu_imm=1, alu_op=000, out_rd=1, out_imm=5.
REQ-025 SHALL check: in 0xFFF00093 with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFF.
REQ-026 SHALL check: 0x0000A103 (lw x2) then 0x002101B3 (add x3,x2,x2), out_ready=1 -> in_ready=0 one cycle, one bubble, add emitted 2 cycles after lw.
REQ-027 SHALL check: 0x402081B3 with out_ready=0 for 3 cycles -> alu_sub=1 held stable, in_ready=0, emitted once.
REQ-028 SHALL check: 0x022081B3 -> is_muldiv=1 with DECODE_MULDIV_EN, illegal=1 and rd_w=0 without.
REQ-029 SHALL check: flush with valid entry and in_valid=1 -> out_valid=0 next cycle, input not accepted.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I decode constants, ALU encodings and control bundle.
// Shared by decode_stage (DECODE_MULDIV_EN enables M decode) and imm_gen.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_imm;
    logic       alu_sub;
    logic       alu_sra;
    logic       rd_w;
    logic       ld_upper;
    logic       add_pc;
    logic       jmp_reg;
    logic       is_branch;
    logic       is_jmp;
    logic       is_load;
    logic       is_store;
    logic       illegal;
    logic       is_muldiv;
  } ctrl_t;

  function automatic logic reads_rs1(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    return opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for I/S/B/U/J formats.
// Built at 32 bits, then sign-extended to XLEN.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (fmt)
      IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                      inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm32 = {inst[31:12], 12'h000};
      IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                      inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with a one-entry output register and load-use stall.
// Define DECODE_MULDIV_EN to decode the M-extension OP group.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      alu_op,
  output logic            alu_imm,
  output logic            alu_sub,
  output logic            alu_sra,
  output logic            rd_w,
  output logic            ld_upper,
  output logic            add_pc,
  output logic            jmp_reg,
  output logic            is_branch,
  output logic            is_jmp,
  output logic            is_load,
  output logic            is_store,
  output logic            illegal,
  output logic            is_muldiv
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];
  assign rd  = in_inst[11:7];
  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];

  logic op_lui, op_auipc, op_jal, op_jalr, op_branch;
  logic op_load, op_store, op_opimm, op_op, op_misc;

  assign op_lui    = opc == OPC_LUI;
  assign op_auipc  = opc == OPC_AUIPC;
  assign op_jal    = opc == OPC_JAL;
  assign op_jalr   = opc == OPC_JALR;
  assign op_branch = opc == OPC_BRANCH;
  assign op_load   = opc == OPC_LOAD;
  assign op_store  = opc == OPC_STORE;
  assign op_opimm  = opc == OPC_OPIMM;
  assign op_op     = opc == OPC_OP;
  assign op_misc   = opc == OPC_FENCE || opc == OPC_SYSTEM;

  ctrl_t           dec;
  imm_fmt_e        fmt;
  logic            legal;
  logic            shamt_ok;
  logic [XLEN-1:0] imm_dec;

  // shamt bit 5 only exists on 64-bit datapaths
  assign shamt_ok = (XLEN == 64) || !in_inst[25];

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst(in_inst[31:7]),
    .fmt (fmt),
    .imm (imm_dec)
  );

  always_comb begin
    dec   = '0;
    fmt   = IMM_R;
    legal = 1'b1;
    unique case (1'b1)
      op_lui: begin
        fmt          = IMM_U;
        dec.rd_w     = 1'b1;
        dec.ld_upper = 1'b1;
        dec.alu_imm  = 1'b1;
      end
      op_auipc: begin
        fmt         = IMM_U;
        dec.rd_w    = 1'b1;
        dec.add_pc  = 1'b1;
        dec.alu_imm = 1'b1;
      end
      op_jal: begin
        fmt         = IMM_J;
        dec.rd_w    = 1'b1;
        dec.is_jmp  = 1'b1;
        dec.add_pc  = 1'b1;
        dec.alu_imm = 1'b1;
      end
      op_jalr: begin
        fmt         = IMM_I;
        dec.rd_w    = 1'b1;
        dec.is_jmp  = 1'b1;
        dec.jmp_reg = 1'b1;
        dec.alu_imm = 1'b1;
        legal       = f3 == ALU_ADD;
      end
      op_branch: begin
        fmt           = IMM_B;
        dec.is_branch = 1'b1;
        dec.add_pc    = 1'b1;
        legal         = f3[2:1] != 2'b01;
      end
      op_load: begin
        fmt         = IMM_I;
        dec.rd_w    = 1'b1;
        dec.is_load = 1'b1;
        dec.alu_imm = 1'b1;
        legal       = f3 != 3'b011 && f3[2:1] != 2'b11;
      end
      op_store: begin
        fmt          = IMM_S;
        dec.is_store = 1'b1;
        dec.alu_imm  = 1'b1;
        legal        = !f3[2] && f3[1:0] != 2'b11;
      end
      op_opimm: begin
        fmt         = IMM_I;
        dec.rd_w    = 1'b1;
        dec.alu_imm = 1'b1;
        dec.alu_op  = f3;
        if (f3 == ALU_SLL) begin
          legal = f7[6:1] == 6'b000000 && shamt_ok;
        end else if (f3 == ALU_SR) begin
          legal = (f7[6:1] == 6'b000000 || f7[6:1] == 6'b010000)
                  && shamt_ok;
          dec.alu_sra = f7[5];
        end
      end
      op_op: begin
        unique case (f7)
          F7_BASE: begin
            dec.rd_w   = 1'b1;
            dec.alu_op = f3;
          end
          F7_ALT: begin
            legal       = f3 == ALU_ADD || f3 == ALU_SR;
            dec.rd_w    = 1'b1;
            dec.alu_op  = f3;
            dec.alu_sub = f3 == ALU_ADD;
            dec.alu_sra = f3 == ALU_SR;
          end
          F7_MULDIV: begin
`ifdef DECODE_MULDIV_EN
            dec.rd_w      = 1'b1;
            dec.is_muldiv = 1'b1;
            dec.alu_op    = f3;
`else
            legal = 1'b0;
`endif
          end
          default: legal = 1'b0;
        endcase
      end
      op_misc: fmt = IMM_I;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec = '0;
    end
    dec.illegal = !legal;
    if (rd == 5'd0) begin
      dec.rd_w = 1'b0;
    end
  end

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;

  logic hazard;
  logic rs1_hit;
  logic rs2_hit;
  logic accept;

  assign rs1_hit = reads_rs1(opc) && rs1 == rd_q;
  assign rs2_hit = reads_rs2(opc) && rs2 == rd_q;
  assign hazard  = valid_q && ctrl_q.is_load && rd_q != 5'd0
                   && in_valid && (rs1_hit || rs2_hit);

  assign in_ready = !rst && (!valid_q || out_ready)
                    && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = dec;
      pc_d    = in_pc;
      imm_d   = imm_dec;
      rd_d    = rd;
      rs1_d   = rs1;
      rs2_d   = rs2;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_imm   = imm_q;
  assign out_rd    = rd_q;
  assign out_rs1   = rs1_q;
  assign out_rs2   = rs2_q;
  assign alu_op    = ctrl_q.alu_op;
  assign alu_imm   = ctrl_q.alu_imm;
  assign alu_sub   = ctrl_q.alu_sub;
  assign alu_sra   = ctrl_q.alu_sra;
  assign rd_w      = ctrl_q.rd_w;
  assign ld_upper  = ctrl_q.ld_upper;
  assign add_pc    = ctrl_q.add_pc;
  assign jmp_reg   = ctrl_q.jmp_reg;
  assign is_branch = ctrl_q.is_branch;
  assign is_jmp    = ctrl_q.is_jmp;
  assign is_load   = ctrl_q.is_load;
  assign is_store  = ctrl_q.is_store;
  assign illegal   = ctrl_q.illegal;
  assign is_muldiv = ctrl_q.is_muldiv;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=64) with a behavioural
// decode model and a one-entry output scoreboard.
module tb_decode_stage;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      alu_op;
  logic alu_imm, alu_sub, alu_sra, rd_w, ld_upper, add_pc, jmp_reg;
  logic is_branch, is_jmp, is_load, is_store, illegal, is_muldiv;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm),
    .alu_op(alu_op), .alu_imm(alu_imm), .alu_sub(alu_sub),
    .alu_sra(alu_sra), .rd_w(rd_w), .ld_upper(ld_upper),
    .add_pc(add_pc), .jmp_reg(jmp_reg), .is_branch(is_branch),
    .is_jmp(is_jmp), .is_load(is_load), .is_store(is_store),
    .illegal(illegal), .is_muldiv(is_muldiv)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  alu_op;
    logic alu_imm, alu_sub, alu_sra, rd_w, ld_upper, add_pc, jmp_reg;
    logic is_branch, is_jmp, is_load, is_store, illegal, is_muldiv;
  } exp_t;

  function automatic exp_t observed();
    exp_t o;
    o = '0;
    o.pc = out_pc; o.imm = out_imm;
    o.rd = out_rd; o.rs1 = out_rs1; o.rs2 = out_rs2;
    o.alu_op = alu_op; o.alu_imm = alu_imm; o.alu_sub = alu_sub;
    o.alu_sra = alu_sra; o.rd_w = rd_w; o.ld_upper = ld_upper;
    o.add_pc = add_pc; o.jmp_reg = jmp_reg; o.is_branch = is_branch;
    o.is_jmp = is_jmp; o.is_load = is_load; o.is_store = is_store;
    o.illegal = illegal; o.is_muldiv = is_muldiv;
    return o;
  endfunction

  function automatic bit uses_rs1(input logic [6:0] opc);
    return !(opc inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic bit uses_rs2(input logic [6:0] opc);
    return opc inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Decoding rules of the ISA, field by field.
  function automatic exp_t ref_decode(input logic [31:0] i,
                                      input logic [63:0] pc);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    bit ok;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; ok = 1;
    s12 = i[31:20];
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    u32 = {i[31:12], 12'h000};
    e = '0;
    e.pc = pc; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    case (opc)
      7'h37: begin e.imm = u32; e.rd_w = 1; e.ld_upper = 1; e.alu_imm = 1; end
      7'h17: begin e.imm = u32; e.rd_w = 1; e.add_pc = 1; e.alu_imm = 1; end
      7'h6F: begin
        e.imm = j21; e.rd_w = 1; e.is_jmp = 1; e.add_pc = 1; e.alu_imm = 1;
      end
      7'h67: begin
        e.imm = s12; e.rd_w = 1; e.is_jmp = 1; e.jmp_reg = 1; e.alu_imm = 1;
        ok = f3 == 0;
      end
      7'h63: begin
        e.imm = b13; e.is_branch = 1; e.add_pc = 1;
        ok = f3 inside {0, 1, 4, 5, 6, 7};
      end
      7'h03: begin
        e.imm = s12; e.rd_w = 1; e.is_load = 1; e.alu_imm = 1;
        ok = f3 inside {0, 1, 2, 4, 5};
      end
      7'h23: begin
        s12 = {i[31:25], i[11:7]};
        e.imm = s12; e.is_store = 1; e.alu_imm = 1;
        ok = f3 inside {0, 1, 2};
      end
      7'h13: begin
        e.imm = s12; e.rd_w = 1; e.alu_imm = 1; e.alu_op = f3;
        if (f3 == 1) ok = i[31:26] == 0;
        if (f3 == 5) begin
          ok = i[31:26] inside {6'h00, 6'h10};
          e.alu_sra = i[30];
        end
      end
      7'h33: begin
        if (f7 == 7'h00) begin
          e.rd_w = 1; e.alu_op = f3;
        end else if (f7 == 7'h20) begin
          ok = f3 inside {0, 5};
          e.rd_w = 1; e.alu_op = f3;
          e.alu_sub = f3 == 0; e.alu_sra = f3 == 5;
        end else if (f7 == 7'h01) begin
`ifdef DECODE_MULDIV_EN
          e.rd_w = 1; e.is_muldiv = 1; e.alu_op = f3;
`else
          ok = 0;
`endif
        end else begin
          ok = 0;
        end
      end
      7'h0F, 7'h73: e.imm = s12;
      default: ok = 0;
    endcase
    if (!ok) begin
      e.alu_op = 0; e.alu_imm = 0; e.alu_sub = 0; e.alu_sra = 0;
      e.rd_w = 0; e.ld_upper = 0; e.add_pc = 0; e.jmp_reg = 0;
      e.is_branch = 0; e.is_jmp = 0; e.is_load = 0; e.is_store = 0;
      e.is_muldiv = 0; e.illegal = 1;
    end
    if (e.rd == 0) e.rd_w = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 13);
    case (k)
      0: i[6:0] = 7'h37;
      1: i[6:0] = 7'h17;
      2: i[6:0] = 7'h6F;
      3: i[6:0] = 7'h67;
      4: i[6:0] = 7'h63;
      5, 11: i[6:0] = 7'h03;
      6: i[6:0] = 7'h23;
      7: i[6:0] = 7'h13;
      8, 12: i[6:0] = 7'h33;
      9: i[6:0] = 7'h0F;
      10: i[6:0] = 7'h32;
      default: ;
    endcase
    case ($urandom_range(0, 4))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      2: i[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) begin
      i[11:7]  = 5'($urandom_range(0, 3));
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
    end
    return i;
  endfunction

  task automatic idle();
    in_valid = 0; out_ready = 1; flush = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t z;
    z = '0;
    rst = 1; in_valid = 1; in_inst = 32'h00500093; out_ready = 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0 || observed() !== z) begin
      n_fail++;
      $display("FAIL rst_state: valid %b fields %h want all 0",
               out_valid, observed());
    end
    rst = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_first_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_first_accept: got %b want 1", out_valid);
    end
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; out_ready = 1;
    n_checks++;
    if (out_valid !== 1'b0 || observed() !== z) begin
      n_fail++;
      $display("FAIL rst_midxfer: valid %b fields %h want 0", out_valid,
               observed());
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard: got %b want 0", out_valid);
    end
  endtask

  task automatic test_addi();
    in_valid = 1; in_inst = 32'h00500093; in_pc = 64'h100; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1 || rd_w !== 1 || alu_imm !== 1 || alu_op !== 3'b000
        || out_rd !== 5'd1 || out_imm !== 64'd5 || out_pc !== 64'h100) begin
      n_fail++;
      $display("FAIL addi: v%b rd_w%b imm%b op%b rd%0d imm=%h pc=%h",
               out_valid, rd_w, alu_imm, alu_op, out_rd, out_imm, out_pc);
    end
    idle();
  endtask

  task automatic test_imm64();
    in_valid = 1; in_inst = 32'hFFF00093; in_pc = 64'h104; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_checks++;
    if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_valid !== 1) begin
      n_fail++;
      $display("FAIL imm64: got %h want ffffffffffffffff", out_imm);
    end
    idle();
  endtask

  task automatic test_load_use();
    in_valid = 1; in_inst = 32'h0000A103; in_pc = 64'h200; out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 1) begin
      n_fail++; $display("FAIL lu_lw_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1 || is_load !== 1 || out_rd !== 5'd2) begin
      n_fail++;
      $display("FAIL lu_lw_out: v%b ld%b rd%0d", out_valid, is_load, out_rd);
    end
    in_inst = 32'h002101B3; in_pc = 64'h204;
    #1;
    n_checks++;
    if (in_ready !== 0) begin
      n_fail++; $display("FAIL lu_stall: in_ready %b want 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++; $display("FAIL lu_bubble: out_valid %b want 0", out_valid);
    end
    #1;
    n_checks++;
    if (in_ready !== 1) begin
      n_fail++; $display("FAIL lu_resume: in_ready %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1 || out_rd !== 5'd3 || out_pc !== 64'h204) begin
      n_fail++;
      $display("FAIL lu_add: v%b rd%0d pc=%h want 1 3 204", out_valid,
               out_rd, out_pc);
    end
    idle();
  endtask

  task automatic test_stall();
    exp_t e;
    e = ref_decode(32'h402081B3, 64'h300);
    in_valid = 1; in_inst = 32'h402081B3; in_pc = 64'h300; out_ready = 1;
    @(negedge clk);
    in_inst = 32'h00500093; in_pc = 64'h304; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1 || alu_sub !== 1 || observed() !== e) begin
        n_fail++;
        $display("FAIL stall_hold%0d: v%b sub%b got %h want %h", c,
                 out_valid, alu_sub, observed(), e);
      end
      #1;
      n_checks++;
      if (in_ready !== 0) begin
        n_fail++; $display("FAIL stall_ready%0d: got %b want 0", c, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++; $display("FAIL stall_once: out_valid %b want 0", out_valid);
    end
    idle();
  endtask

  task automatic test_muldiv();
    in_valid = 1; in_inst = 32'h022081B3; in_pc = 64'h400; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_checks++;
`ifdef DECODE_MULDIV_EN
    if (is_muldiv !== 1 || illegal !== 0 || rd_w !== 1 || alu_op !== 0) begin
      n_fail++;
      $display("FAIL muldiv: md%b ill%b rd_w%b op%b want 1 0 1 000",
               is_muldiv, illegal, rd_w, alu_op);
    end
`else
    if (is_muldiv !== 0 || illegal !== 1 || rd_w !== 0) begin
      n_fail++;
      $display("FAIL muldiv: md%b ill%b rd_w%b want 0 1 0",
               is_muldiv, illegal, rd_w);
    end
`endif
    idle();
  endtask

  task automatic test_flush();
    in_valid = 1; in_inst = 32'h00500093; in_pc = 64'h500; out_ready = 1;
    @(negedge clk);
    flush = 1; in_inst = 32'h12345137; in_pc = 64'h504; out_ready = 0;
    #1;
    n_checks++;
    if (in_ready !== 0 || out_valid !== 1) begin
      n_fail++;
      $display("FAIL flush_pre: ready %b valid %b want 0 1", in_ready,
               out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++; $display("FAIL flush_clear: out_valid %b want 0", out_valid);
    end
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++; $display("FAIL flush_noaccept: out_valid %b want 0", out_valid);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [6];
    exp_t e;
    prog[0] = 32'h12345137;
    prog[1] = 32'hFE20AE23;
    prog[2] = 32'hFF9FF0EF;
    prog[3] = 32'h00208463;
    prog[4] = 32'h0FF0C293;
    prog[5] = 32'h4050D313;
    out_ready = 1; in_valid = 1; in_inst = prog[0]; in_pc = 64'h1000;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      e = ref_decode(prog[k-1], 64'h1000 + 64'(4 * (k - 1)));
      n_checks++;
      if (out_valid !== 1 || observed() !== e) begin
        n_fail++;
        $display("FAIL b2b%0d: v%b got %h want %h", k - 1, out_valid,
                 observed(), e);
      end
      if (k == 2) begin
        n_checks++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
          n_fail++; $display("FAIL b2b_simm: got %h want -4", out_imm);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin
          n_fail++; $display("FAIL b2b_jimm: got %h want -8", out_imm);
        end
      end
      if (k < 6) begin
        in_inst = prog[k]; in_pc = 64'h1000 + 64'(4 * k);
        #1;
        n_checks++;
        if (in_ready !== 1) begin
          n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready);
        end
      end else begin
        in_valid = 0;
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_random();
    exp_t q[$];
    bit hz;
    bit rdy;
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (out_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_valid%0d: got %b want %b", c, out_valid,
                 q.size() != 0);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (observed() !== q[0]) begin
          n_fail++;
          $display("FAIL rnd_fields%0d: got %h want %h", c, observed(), q[0]);
        end
      end
      in_valid  = $urandom_range(0, 3) != 0;
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 15) == 0;
      #1;
      hz = q.size() != 0 && q[0].is_load && q[0].rd != 0 && in_valid
           && ((uses_rs1(in_inst[6:0]) && in_inst[19:15] == q[0].rd)
            || (uses_rs2(in_inst[6:0]) && in_inst[24:20] == q[0].rd));
      rdy = (q.size() == 0 || out_ready) && !hz && !flush;
      n_checks++;
      if (in_ready !== rdy) begin
        n_fail++;
        $display("FAIL rnd_ready%0d: got %b want %b inst=%h", c, in_ready,
                 rdy, in_inst);
      end
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && rdy) q.push_back(ref_decode(in_inst, in_pc));
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    test_reset();
    idle();
    test_addi();
    test_imm64();
    test_load_use();
    test_stall();
    test_muldiv();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
